eager_fork_data: RTL and testbench
==================================

EAGER_FORK_DATA -- requirements
Module: eager_fork_data

Interface
REQ-001 SHALL have parameter SIZE, default 2, number of output channels (>=2).
REQ-002 SHALL have parameter DATA_TYPE, default 32, data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ins  input  DATA_TYPE  incoming data token.
REQ-006 SHALL have port ins_valid  input  1  input token present.
REQ-007 SHALL have port ins_ready  output  1  input token consumed this cycle.
REQ-008 SHALL have port outs  output  SIZE*DATA_TYPE  copy of token per channel; channel i at bits [i*DATA_TYPE +: DATA_TYPE].
REQ-009 SHALL have port outs_valid  output  SIZE  per-channel valid.
REQ-010 SHALL have port outs_ready  input  SIZE  per-channel ready.

Function
REQ-011 SHALL replicate one input token to all SIZE outputs; the input is consumed only after every output has accepted it.
REQ-012 SHALL hold a per-channel "sent" flag sent[i]: set when channel i handshakes while the input token remains pending.
REQ-013 SHALL drive outs_valid[i] = token_valid AND NOT sent[i]; each output is offered independently (eager), never waiting on other channels.
REQ-014 SHALL drive ins_ready = AND over i of (sent[i] OR outs_ready[i]).
REQ-015 On input handshake (token_valid AND ins_ready), SHALL clear all sent[i] the same cycle edge; otherwise sent[i] <= sent[i] OR (outs_valid[i] AND outs_ready[i]).
REQ-016 SHALL forward data combinationally, with zero latency in the base configuration; every outs slice equals the current token data.
REQ-017 Each channel SHALL see exactly one handshake per input token, regardless of ready arrival order.
REQ-018 All outputs ready in the same cycle as ins_valid: token SHALL pass in one cycle, with no sent flag set.
REQ-019 SHALL NOT produce outputs while ins_valid is low, regardless of the sent state; sent flags persist while the input is stalled.
REQ-020 Channels with outs_ready held high after completion SHALL NOT receive a duplicate token.

Reset
REQ-021 Asserting rst SHALL clear all sent flags (and the input register of REQ-023) immediately, independent of clk.
REQ-022 During and after reset: outs_valid = 0 while ins_valid is low; a token partially delivered at reset SHALL be re-offered to all channels.

Configuration
REQ-023 With FORK_IN_REG_EN defined, SHALL insert a one-entry input register (full flag + data):
- ins_ready = NOT full OR fork_accept
- fork operates on the registered token, so latency is 1 cycle
- full and data load on the input handshake
- full clears on fork_accept without a new input
- back-to-back tokens are sustained at one per cycle.
REQ-024 Without FORK_IN_REG_EN, SHALL behave as REQ-011..020 with zero latency and no extra registers.

Structure
REQ-025 No shared package types are required; the default parameter values SHALL live in the team dataflow package as constants.
REQ-026 SHALL use one sub-module, eager_fork_register, instantiated SIZE times, which holds one sent flag and produces outs_valid[i] and the channel's done term.

Verification
REQ-027 SIZE=2, ins=0x0000_0005 valid, outs_ready=11 -> both outs=5 valid in cycle 0, ins_ready=1, sent stays 00.
REQ-028 SIZE=2, outs_ready=01 cycle 0, then 10 cycle 1 -> ch0 handshakes cycle 0, ch1 cycle 1, ins_ready=1 only in cycle 1, one transfer per channel.
REQ-029 SIZE=3, outs_ready=111 held, ins valid over 4 consecutive tokens 1,2,3,4 -> each channel receives 1,2,3,4 in order, no duplicates, no drops.
REQ-030 SIZE=2, ch0 accepted and ch1 stalled, then rst pulsed asynchronously mid-cycle -> sent cleared at once; after release, both channels are offered the token again.
REQ-031 FORK_IN_REG_EN, SIZE=2, token 0xA at cycle 0 with outs_ready=11 -> outs valid at cycle 1; second token 0xB accepted at cycle 1 and output at cycle 2.
REQ-032 ins_valid low and outs_ready=11 for 10 cycles -> outs_valid=00 throughout, ins_ready=1.

Source files
------------

// File: rtl/eager_fork_data_pkg.sv
// Shared constants for the eager fork block.
// Holds the default channel count and data width so every user of the fork
// picks up the same defaults. No ports; imported with eager_fork_data_pkg::*.
package eager_fork_data_pkg;

  localparam int unsigned FORK_SIZE_DEF   = 2;
  localparam int unsigned FORK_DATA_W_DEF = 32;

endpackage : eager_fork_data_pkg

// File: rtl/eager_fork_register.sv
// One channel of the eager fork: holds the channel's "sent" flag.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   valid_i   - token currently presented to the fork
//   ready_i   - downstream ready for this channel
//   clear_i   - token consumed by the fork this cycle; drop the sent flag
//   valid_o   - channel valid (token present and not yet delivered here)
//   done_o    - channel no longer blocks consumption of the token
module eager_fork_register (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic valid_o,
  output logic done_o
);

  logic sent_q;
  logic sent_d;

  assign valid_o = valid_i & ~sent_q;
  // A channel that already delivered, or that accepts now, is finished.
  assign done_o  = sent_q | ready_i;

  always_comb begin
    sent_d = sent_q | (valid_o & ready_i);
    if (clear_i) begin
      sent_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule : eager_fork_register

// File: rtl/eager_fork_data.sv
// Eager fork: replicates one input token to SIZE output channels. Each
// channel is offered the token independently; the input is consumed only
// once every channel has taken its copy.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   ins         - input token data (DATA_TYPE bits)
//   ins_valid   - input token present
//   ins_ready   - input token consumed this cycle
//   outs        - SIZE copies of the token, channel i at [i*DATA_TYPE +: DATA_TYPE]
//   outs_valid  - per-channel valid
//   outs_ready  - per-channel ready
// Build option:
//   FORK_IN_REG_EN - adds a one-entry input register in front of the fork
//                    (1-cycle latency, full throughput). Undefined by default:
//                    purely combinational forwarding.
module eager_fork_data
  import eager_fork_data_pkg::*;
#(
  parameter int unsigned SIZE      = FORK_SIZE_DEF,
  parameter int unsigned DATA_TYPE = FORK_DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);

  logic                 tok_valid;
  logic [DATA_TYPE-1:0] tok_data;
  logic [SIZE-1:0]      done;
  logic                 fork_accept;

  // The token leaves the fork when every channel is done with it.
  assign fork_accept = tok_valid & (&done);

`ifdef FORK_IN_REG_EN
  logic                 full_q;
  logic                 full_d;
  logic [DATA_TYPE-1:0] data_q;
  logic [DATA_TYPE-1:0] data_d;
  logic                 in_hs;

  // Accept a new token when empty, or when the held one leaves this cycle.
  assign ins_ready = ~full_q | fork_accept;
  assign in_hs     = ins_valid & ins_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_hs) begin
      full_d = 1'b1;
      data_d = ins;
    end else if (fork_accept) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign tok_valid = full_q;
  assign tok_data  = data_q;
`else
  assign tok_valid = ins_valid;
  assign tok_data  = ins;
  // Independent of ins_valid so that an idle fork reports ready.
  assign ins_ready = &done;
`endif

  for (genvar i = 0; i < SIZE; i++) begin : g_chan
    assign outs[i*DATA_TYPE +: DATA_TYPE] = tok_data;

    eager_fork_register u_reg (
      .clk     (clk),
      .rst     (rst),
      .valid_i (tok_valid),
      .ready_i (outs_ready[i]),
      .clear_i (fork_accept),
      .valid_o (outs_valid[i]),
      .done_o  (done[i])
    );
  end

endmodule : eager_fork_data

// File: tb/tb_eager_fork_data.sv
module tb_eager_fork_data;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] ins2;
  logic        v2;
  logic        ir2;
  logic [63:0] outs2;
  logic [1:0]  ov2;
  logic [1:0]  r2;

  logic [31:0] ins3;
  logic        v3;
  logic        ir3;
  logic [95:0] outs3;
  logic [2:0]  ov3;
  logic [2:0]  r3;

  int errors = 0;
  int checks = 0;

  typedef logic [31:0] dq_t[$];
  dq_t sb2[2];
  dq_t sb3[3];

  always #5 clk = ~clk;

  eager_fork_data #(.SIZE(2), .DATA_TYPE(32)) dut2 (
    .clk(clk), .rst(rst), .ins(ins2), .ins_valid(v2), .ins_ready(ir2),
    .outs(outs2), .outs_valid(ov2), .outs_ready(r2)
  );

  eager_fork_data #(.SIZE(3), .DATA_TYPE(32)) dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(ir3),
    .outs(outs3), .outs_valid(ov3), .outs_ready(r3)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [31:0] d);
    sb2[0].push_back(d);
    sb2[1].push_back(d);
  endtask

  // Scoreboard monitor: every output handshake must match the next expected token.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ov2[i] && r2[i]) begin
        if (sb2[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_ch%0d unexpected: got %0h expected none", i, outs2[i*32 +: 32]);
        end else begin
          chk($sformatf("sb2_ch%0d", i), {32'h0, outs2[i*32 +: 32]}, {32'h0, sb2[i].pop_front()});
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (ov3[i] && r3[i]) begin
        if (sb3[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL sb3_ch%0d unexpected: got %0h expected none", i, outs3[i*32 +: 32]);
        end else begin
          chk($sformatf("sb3_ch%0d", i), {32'h0, outs3[i*32 +: 32]}, {32'h0, sb3[i].pop_front()});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ins2 = '0; v2 = 1'b0; r2 = 2'b00;
    ins3 = '0; v3 = 1'b0; r3 = 3'b000;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_ov2", {62'h0, ov2}, 64'h0);
    chk("rst_ir2", {63'h0, ir2}, 64'h0);
    chk("rst_ov3", {61'h0, ov3}, 64'h0);
    nxt();
    rst = 1'b0;

    // Idle with all ready: nothing offered, input ready.
    r2 = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ov2", {62'h0, ov2}, 64'h0);
      chk("idle_ir2", {63'h0, ir2}, 64'h1);
      nxt();
    end

`ifdef FORK_IN_REG_EN
    // Registered input: one cycle latency, back-to-back tokens.
    ins2 = 32'hA; v2 = 1'b1; r2 = 2'b11; push2(32'hA);
    @(negedge clk);
    chk("reg_c0_ov", {62'h0, ov2}, 64'h0);
    chk("reg_c0_ir", {63'h0, ir2}, 64'h1);
    nxt();
    ins2 = 32'hB; push2(32'hB);
    @(negedge clk);
    chk("reg_c1_ov", {62'h0, ov2}, 64'h3);
    chk("reg_c1_outs", outs2, {2{32'hA}});
    chk("reg_c1_ir", {63'h0, ir2}, 64'h1);
    nxt();
    v2 = 1'b0;
    @(negedge clk);
    chk("reg_c2_ov", {62'h0, ov2}, 64'h3);
    chk("reg_c2_outs", outs2, {2{32'hB}});
    nxt();
    @(negedge clk);
    chk("reg_c3_ov", {62'h0, ov2}, 64'h0);
    nxt();
`else
    // All ready together: single-cycle pass.
    ins2 = 32'h5; v2 = 1'b1; r2 = 2'b11; push2(32'h5);
    @(negedge clk);
    chk("all_rdy_ov", {62'h0, ov2}, 64'h3);
    chk("all_rdy_outs", outs2, {2{32'h5}});
    chk("all_rdy_ir", {63'h0, ir2}, 64'h1);
    nxt();

    // ch0 first then ch1; also shows no sent flag lingered from the previous token.
    ins2 = 32'h7; r2 = 2'b01; push2(32'h7);
    @(negedge clk);
    chk("ord01_c0_ov", {62'h0, ov2}, 64'h3);
    chk("ord01_c0_ir", {63'h0, ir2}, 64'h0);
    nxt();
    r2 = 2'b10;
    @(negedge clk);
    chk("ord01_c1_ov", {62'h0, ov2}, 64'h2);
    chk("ord01_c1_ir", {63'h0, ir2}, 64'h1);
    nxt();

    // ch1 first then ch0.
    ins2 = 32'h9; r2 = 2'b10; push2(32'h9);
    @(negedge clk);
    chk("ord10_c0_ir", {63'h0, ir2}, 64'h0);
    nxt();
    r2 = 2'b01;
    @(negedge clk);
    chk("ord10_c1_ov", {62'h0, ov2}, 64'h1);
    chk("ord10_c1_ir", {63'h0, ir2}, 64'h1);
    nxt();

    // ch0 ready held while ch1 stalls: no duplicate to ch0.
    ins2 = 32'h21; r2 = 2'b01; push2(32'h21);
    nxt();
    @(negedge clk);
    chk("hold_ov", {62'h0, ov2}, 64'h2);
    chk("hold_ir", {63'h0, ir2}, 64'h0);
    nxt();
    r2 = 2'b11;
    @(negedge clk);
    chk("hold_done_ir", {63'h0, ir2}, 64'h1);
    nxt();

    // Input withdrawn mid-token: no outputs, sent flag kept.
    ins2 = 32'h31; r2 = 2'b01; push2(32'h31);
    nxt();
    v2 = 1'b0; r2 = 2'b00;
    @(negedge clk);
    chk("stall_ov", {62'h0, ov2}, 64'h0);
    nxt();
    v2 = 1'b1;
    @(negedge clk);
    chk("stall_resume_ov", {62'h0, ov2}, 64'h2);
    nxt();
    r2 = 2'b10;
    @(negedge clk);
    chk("stall_done_ir", {63'h0, ir2}, 64'h1);
    nxt();

    // Asynchronous reset with ch0 delivered and ch1 stalled.
    ins2 = 32'h41; r2 = 2'b01; push2(32'h41);
    nxt();
    r2 = 2'b00;
    @(negedge clk);
    chk("pre_rst_ov", {62'h0, ov2}, 64'h2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ov", {62'h0, ov2}, 64'h3);
    chk("async_rst_ir", {63'h0, ir2}, 64'h0);
    #1 rst = 1'b0;
    sb2[0].push_back(32'h41);
    nxt();
    @(negedge clk);
    chk("post_rst_ov", {62'h0, ov2}, 64'h3);
    nxt();
    r2 = 2'b11;
    @(negedge clk);
    chk("post_rst_ir", {63'h0, ir2}, 64'h1);
    nxt();
    v2 = 1'b0;
`endif

    // Three channels, four back-to-back tokens.
    r3 = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      ins3 = k; v3 = 1'b1;
      for (int i = 0; i < 3; i++) sb3[i].push_back(k);
      @(negedge clk);
      chk("b2b_ir3", {63'h0, ir3}, 64'h1);
`ifndef FORK_IN_REG_EN
      chk("b2b_ov3", {61'h0, ov3}, 64'h7);
`endif
      nxt();
    end
    v3 = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("end_ov3", {61'h0, ov3}, 64'h0);

    for (int i = 0; i < 2; i++) chk($sformatf("sb2_left_ch%0d", i), sb2[i].size(), 64'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("sb3_left_ch%0d", i), sb3[i].size(), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_eager_fork_data
